audio_i2s_shifter: RTL and testbench
====================================

AUDIO_I2S_SHIFTER -- requirements
Module: audio_i2s_shifter

Interface
REQ-001 SHALL have parameter CLKDIV, default 16, the number of clk cycles per half-period of aud_bclk; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock (sysclk) for all sequential logic.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port ldata, input, 16 bits: left-channel sample, two's complement.
REQ-005 SHALL have port rdata, input, 16 bits: right-channel sample, two's complement.
REQ-006 SHALL have port exchan, input, 1 bit: when 1, the left and right channels are swapped.
REQ-007 SHALL have port sample_ack, output, 1 bit: a one-clk pulse when ldata and rdata are captured.
REQ-008 SHALL have port aud_xck, output, 1 bit: codec master clock, equal to clk divided by 2.
REQ-009 SHALL have port aud_bclk, output, 1 bit: I2S bit clock.
REQ-010 SHALL have port aud_daclrck, output, 1 bit: I2S word select; 0 selects left, 1 selects right.
REQ-011 SHALL have port aud_dacdat, output, 1 bit: I2S serial data, MSB first.

Function
REQ-012 SHALL toggle aud_xck on every clk edge of the active level, giving clk/2.
REQ-013 SHALL run a prescaler that counts 0..CLKDIV-1 and wraps to 0; aud_bclk SHALL toggle on the clk cycle where the prescaler is at CLKDIV-1.
REQ-014 SHALL treat a terminal count with aud_bclk=1 as a falling event; on each falling event a 5-bit bit_cnt SHALL increment and wrap 31->0.
REQ-015 SHALL update aud_daclrck, aud_dacdat and the shift register only on falling events; all outputs SHALL be registered, with no combinational path from the inputs.
REQ-016 SHALL drive aud_daclrck to bit_cnt[4] (the new count value) after each falling event.
REQ-017 SHALL, on the falling event where bit_cnt becomes 1, load the 32-bit shift register with {chanA, chanB} and drive aud_dacdat with its MSB.
REQ-018 SHALL use chanA=ldata and chanB=rdata when exchan=0, and chanA=rdata and chanB=ldata when exchan=1; exchan SHALL be sampled only at the load.
REQ-019 SHALL, on every other falling event, shift the register left by 1 and drive aud_dacdat with the new MSB; at bit_cnt=0 the output is the LSB of the previous right word, which is the standard I2S one-bit delay.
REQ-020 SHALL assert sample_ack for exactly the one clk cycle in which the load occurs.
REQ-021 SHALL ignore changes on ldata, rdata or exchan between loads.
REQ-022 SHALL have frame period 64*CLKDIV clk cycles, and one load per frame.

Reset
REQ-023 SHALL, while rst_n=0, hold prescaler=0, bit_cnt=0, shift register=0, aud_xck=0, aud_bclk=0, aud_daclrck=0, aud_dacdat=0 and sample_ack=0.
REQ-024 SHALL, when reset is asserted mid-frame, abort the frame immediately; after release the first falling event occurs 2*CLKDIV clk cycles later and performs a load, because bit_cnt goes 0->1.

Configuration
REQ-025 SHALL, with macro AUDIO_SHIFTER_MIX_EN defined, load chanA'=(3*chanA+chanB)>>>2 and chanB'=(3*chanB+chanA)>>>2 instead of chanA and chanB.
REQ-026 SHALL compute the mix in 18-bit signed arithmetic with an arithmetic shift and keep the low 16 bits; no saturation is needed because the result cannot overflow.
REQ-027 SHALL, without AUDIO_SHIFTER_MIX_EN, load chanA and chanB unmodified and synthesise no mix logic.

Verification (CLKDIV=2)
REQ-028 SHALL verify reset timing: release rst_n -> aud_bclk rises at clk 2, first falling event and sample_ack at clk 4, aud_bclk period 4 clk, frame 128 clk.
REQ-029 SHALL verify serial data: ldata=16'hA55A, rdata=16'h0F0F, exchan=0 -> bits 1..16 = A55A MSB first with aud_daclrck=0 at counts 1..15; bits 17..32 (count 0 of next frame is the last) = 0F0F, aud_daclrck=1 at counts 16..31.
REQ-030 SHALL verify channel swap: exchan=1, ldata=16'h1234, rdata=16'h8001 -> left slot carries 8001 and right slot carries 1234.
REQ-031 SHALL verify input isolation: change ldata at counts 5 and 20 -> the current frame is unchanged and the value present at the next load is transmitted.
REQ-032 SHALL verify the mix with AUDIO_SHIFTER_MIX_EN defined: ldata=16'h4000, rdata=0 -> left slot 16'h3000, right slot 16'h1000; ldata=16'h8000, rdata=16'h8000 -> both slots 16'h8000.
REQ-033 SHALL verify reset mid-frame: assert rst_n=0 at count 9 -> all outputs 0 within the same cycle; after release, a fresh load with sample_ack occurs at clk 4.

Source files
------------

// File: rtl/audio_i2s_shifter.sv
// -----------------------------------------------------------------------------
// audio_i2s_shifter
//
// Purpose: serialises a stereo pair of 16-bit two's-complement samples onto an
// I2S DAC link. The block is the bus master: it generates the codec master
// clock, the bit clock and the word select from the single system clock. It
// then shifts each 32-bit frame out MSB first, with the standard one-bit
// delay after each word-select change.
//
// Capture protocol: there is no valid/ready handshake. ldata/rdata/exchan are
// sampled once per frame on the load falling event, and sample_ack pulses for
// that one clk cycle. Values presented at any other time are ignored.
//
// Parameters:
//   CLKDIV       clk cycles per half-period of aud_bclk (2..255)
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   rst_n        asynchronous active-low reset
//   ldata        left-channel sample
//   rdata        right-channel sample
//   exchan       1 = swap left/right at the next load
//   sample_ack   one-cycle pulse when ldata/rdata are captured
//   aud_xck      codec master clock, clk/2
//   aud_bclk     I2S bit clock
//   aud_daclrck  I2S word select (0 = left, 1 = right)
//   aud_dacdat   I2S serial data, MSB first
//
// Build option:
//   AUDIO_SHIFTER_MIX_EN  when defined, a 3:1 cross-mix of the two channels is
//                         loaded instead of the raw samples.
// -----------------------------------------------------------------------------
module audio_i2s_shifter #(
  parameter int CLKDIV = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ldata,
  input  logic [15:0] rdata,
  input  logic        exchan,
  output logic        sample_ack,
  output logic        aud_xck,
  output logic        aud_bclk,
  output logic        aud_daclrck,
  output logic        aud_dacdat
);

  localparam logic [7:0] TC_VAL = 8'(CLKDIV - 1);

  logic [7:0]  presc_q, presc_d;
  logic        xck_q;
  logic        bclk_q, bclk_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic        ack_q, ack_d;

  logic        tc;
  logic        fall;
  logic        load;
  logic [15:0] chan_a, chan_b;
  logic [31:0] load_word;

`ifdef AUDIO_SHIFTER_MIX_EN
  logic signed [17:0] a_ext, b_ext;
  logic signed [17:0] sum_a, sum_b;
`endif

  // Channel ordering and optional mix of the word to be loaded.
  always_comb begin
    chan_a = exchan ? rdata : ldata;
    chan_b = exchan ? ldata : rdata;
`ifdef AUDIO_SHIFTER_MIX_EN
    a_ext = $signed({{2{chan_a[15]}}, chan_a});
    b_ext = $signed({{2{chan_b[15]}}, chan_b});
    // 3*x + y spans at most 18 signed bits, so the sum cannot wrap; after the
    // arithmetic /4 the result always fits back into 16 bits.
    sum_a = a_ext + a_ext + a_ext + b_ext;
    sum_b = b_ext + b_ext + b_ext + a_ext;
    load_word = {16'(sum_a >>> 2), 16'(sum_b >>> 2)};
`else
    load_word = {chan_a, chan_b};
`endif
  end

  // Prescaler terminal count drives every bit-clock edge; the falling edge is
  // the terminal count seen while the bit clock is currently high.
  always_comb begin
    tc        = (presc_q == TC_VAL);
    fall      = tc && bclk_q;
    // The load happens on the falling event that takes bit_cnt from 0 to 1.
    load      = fall && (bit_cnt_q == 5'd0);

    presc_d   = tc ? 8'd0 : presc_q + 8'd1;
    bclk_d    = tc ? ~bclk_q : bclk_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ack_d     = load;

    if (fall) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      if (load) begin
        shreg_d = load_word;
      end else begin
        shreg_d = {shreg_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= 8'd0;
      xck_q     <= 1'b0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= 5'd0;
      shreg_q   <= 32'd0;
      ack_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      xck_q     <= ~xck_q;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ack_q     <= ack_d;
    end
  end

  // Every output is a flop: the serial bit is the shift-register MSB and the
  // word select is the top bit of the post-increment bit counter.
  assign aud_xck     = xck_q;
  assign aud_bclk    = bclk_q;
  assign aud_daclrck = bit_cnt_q[4];
  assign aud_dacdat  = shreg_q[31];
  assign sample_ack  = ack_q;

endmodule

// File: tb/tb_audio_i2s_shifter.sv
module tb_audio_i2s_shifter;

  localparam int CLKDIV = 2;
  localparam int BITP   = 2 * CLKDIV;    // clk cycles per bit
  localparam int FRAME  = 64 * CLKDIV;   // clk cycles per frame

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ldata = 16'h0;
  logic [15:0] rdata = 16'h0;
  logic        exchan = 1'b0;
  logic        sample_ack;
  logic        aud_xck;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_dacdat;

  always #5 clk = ~clk;

  audio_i2s_shifter #(.CLKDIV(CLKDIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ldata       (ldata),
    .rdata       (rdata),
    .exchan      (exchan),
    .sample_ack  (sample_ack),
    .aud_xck     (aud_xck),
    .aud_bclk    (aud_bclk),
    .aud_daclrck (aud_daclrck),
    .aud_dacdat  (aud_dacdat)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          tests = 0;
  int          failed = 0;
  int          n = 0;            // clk edges since reset release
  bit          in_reset = 1'b1;
  bit          have_word = 1'b0;
  logic [31:0] cur_word = 32'h0;
  logic [31:0] exp_q[$];

  // Expected 32-bit frame word for a given input set.
  function automatic logic [31:0] make_word(input logic [15:0] l,
                                            input logic [15:0] r,
                                            input logic ex);
    logic [15:0] a;
    logic [15:0] b;
`ifdef AUDIO_SHIFTER_MIX_EN
    int          sa;
    int          sb;
    logic [31:0] ta;
    logic [31:0] tb;
`endif
    a = ex ? r : l;
    b = ex ? l : r;
`ifdef AUDIO_SHIFTER_MIX_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
    ta = (3 * sa + sb) >>> 2;
    tb = (3 * sb + sa) >>> 2;
    return {ta[15:0], tb[15:0]};
`else
    return {a, b};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h n=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_xck"},  32'(aud_xck),     32'd0);
    chk({tag, "_bclk"}, 32'(aud_bclk),    32'd0);
    chk({tag, "_lrck"}, 32'(aud_daclrck), 32'd0);
    chk({tag, "_dat"},  32'(aud_dacdat),  32'd0);
    chk({tag, "_ack"},  32'(sample_ack),  32'd0);
  endtask

  // One clk cycle: sample outputs 1 time unit after the edge and compare them
  // with the frame timing computed from the cycle count since reset release.
  task automatic tick();
    int f;
    int cnt;
    int p;
    bit load_now;
    logic exp_dat;
    @(posedge clk);
    #1;
    if (in_reset) begin
      chk_zero_outputs("reset");
    end else begin
      n++;
      f        = n / BITP;
      cnt      = f % 32;
      load_now = ((n % FRAME) == BITP);
      if (load_now) begin
        chk("queue_nonempty_at_load", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur_word  = exp_q.pop_front();
          have_word = 1'b1;
        end
      end
      exp_dat = 1'b0;
      if (f >= 1 && have_word) begin
        p       = (f - 1) % 32;
        exp_dat = cur_word[31 - p];
      end
      chk("xck",  32'(aud_xck),     32'(n % 2));
      chk("bclk", 32'(aud_bclk),    32'((n / CLKDIV) % 2));
      chk("lrck", 32'(aud_daclrck), 32'((cnt >> 4) & 1));
      chk("ack",  32'(sample_ack),  32'(load_now));
      chk("dat",  32'(aud_dacdat),  32'(exp_dat));
    end
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic drive(input logic [15:0] l, input logic [15:0] r,
                       input logic ex);
    ldata  = l;
    rdata  = r;
    exchan = ex;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] rl;
    logic [15:0] rr;
    logic        rx;

    // Reset held: everything must be zero.
    rst_n = 1'b0;
    in_reset = 1'b1;
    repeat (3) tick();

    // Frame 0: basic serial data, loaded 2*CLKDIV cycles after release.
    drive(16'hA55A, 16'h0F0F, 1'b0);
    exp_q.push_back(make_word(16'hA55A, 16'h0F0F, 1'b0));
    rst_n = 1'b1;
    in_reset = 1'b0;
    n = 0;

    // Frame 1: swap, driven right after frame 0's load (must not affect it).
    run_to(10);
    drive(16'h1234, 16'h8001, 1'b1);
    exp_q.push_back(make_word(16'h1234, 16'h8001, 1'b1));

    // Frame 2 word, then disturb ldata at counts 5 and 20 of frame 2.
    run_to(FRAME + 10);
    drive(16'h1111, 16'h2222, 1'b0);
    exp_q.push_back(make_word(16'h1111, 16'h2222, 1'b0));
    run_to(2 * FRAME + 5 * BITP + 1);
    ldata = 16'h3333;
    run_to(2 * FRAME + 20 * BITP + 1);
    ldata = 16'h4444;
    exp_q.push_back(make_word(16'h4444, 16'h2222, 1'b0));

    // Frames 4 and 5: mix corner values (plain pass-through without the mix).
    run_to(3 * FRAME + 20);
    drive(16'h4000, 16'h0000, 1'b0);
    exp_q.push_back(make_word(16'h4000, 16'h0000, 1'b0));
    run_to(4 * FRAME + 20);
    drive(16'h8000, 16'h8000, 1'b0);
    exp_q.push_back(make_word(16'h8000, 16'h8000, 1'b0));

    // Frames 6 and 7: random samples.
    run_to(5 * FRAME + 20);
    rl = 16'($urandom_range(0, 65535));
    rr = 16'($urandom_range(0, 65535));
    rx = 1'($urandom_range(0, 1));
    drive(rl, rr, rx);
    exp_q.push_back(make_word(rl, rr, rx));
    run_to(6 * FRAME + 20);
    rl = 16'($urandom_range(0, 65535));
    rr = 16'($urandom_range(0, 65535));
    rx = 1'($urandom_range(0, 1));
    drive(rl, rr, rx);
    exp_q.push_back(make_word(rl, rr, rx));

    // Reset mid-frame at count 9 of frame 7: outputs clear without a clock.
    run_to(7 * FRAME + 9 * BITP + 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    in_reset  = 1'b1;
    have_word = 1'b0;
    chk("queue_empty_before_restart", 32'(exp_q.size()), 32'd0);
    rl = 16'($urandom_range(0, 65535));
    rr = 16'($urandom_range(0, 65535));
    drive(rl, rr, 1'b0);
    exp_q.push_back(make_word(rl, rr, 1'b0));
    repeat (2) tick();
    rst_n = 1'b1;
    in_reset = 1'b0;
    n = 0;

    // Fresh frame after reset, including its trailing count-0 bit.
    run_to(FRAME + BITP - 1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
